alu_control_seq: RTL

Phase-2 ALU control: decodes a 2-bit ALU class plus a parametrised function field into an operation code and registers it into the EX-stage control slot. Adds a valid/ready handshake, pipeline stall and flush, illegal-function flagging, and multi-cycle occupancy for long operations (MUL). Sits between the ID-stage decoder and the ALU; drives the ALU operation select and back-pressures ID while a multi-cycle op is in progress.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 62 ++++++
 rtl/alu_control_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU control shared definitions: operation codes, alu_op class
// encodings and funct[2:0] values used by the decoder and sequencer.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_ADD   = 4'd3,
    OP_NOT   = 4'd4,
    OP_NOP   = 4'd5,
    OP_SUB   = 4'd6,
    OP_AND   = 4'd7,
    OP_MUL   = 4'd8,
    OP_PASS  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    CLS_NOP   = 2'b00,
    CLS_FUNCT = 2'b01,
    CLS_ADDR  = 2'b10,
    CLS_PASS  = 2'b11
  } alu_cls_e;

  localparam logic [2:0] F_NOP   = 3'b000;
  localparam logic [2:0] F_LOAD  = 3'b001;
  localparam logic [2:0] F_STORE = 3'b010;
  localparam logic [2:0] F_ADD   = 3'b011;
  localparam logic [2:0] F_NOT   = 3'b100;
  localparam logic [2:0] F_SUB   = 3'b101;
  localparam logic [2:0] F_AND   = 3'b110;
  localparam logic [2:0] F_MUL   = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, funct} -> {operation, is_multi, illegal}.
// Ports: alu_op/funct in; operation/is_multi/illegal out. Macro ALU_CTRL_MUL_EN.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 3,
  parameter int OP_W    = 4
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OP_W-1:0]    operation,
  output logic               is_multi,
  output logic               illegal
);

  logic hi_nz;
  op_e  op;

  // Any set bit above [2:0] makes a function-decoded op illegal.
  if (FUNCT_W > 3) begin : g_hi
    assign hi_nz = |funct[FUNCT_W-1:3];
  end else begin : g_no_hi
    assign hi_nz = 1'b0;
  end

  always_comb begin
    op       = OP_NOP;
    is_multi = 1'b0;
    illegal  = 1'b0;
    unique case (alu_op)
      CLS_NOP:  op = OP_NOP;
      CLS_ADDR: op = OP_ADD;
      CLS_PASS: op = OP_PASS;
      default: begin
        if (hi_nz) begin
          illegal = 1'b1;
        end else begin
          unique case (funct[2:0])
            F_NOP:   op = OP_NOP;
            F_LOAD:  op = OP_LOAD;
            F_STORE: op = OP_STORE;
            F_ADD:   op = OP_ADD;
            F_NOT:   op = OP_NOT;
            F_SUB:   op = OP_SUB;
            F_AND:   op = OP_AND;
            F_MUL: begin
`ifdef ALU_CTRL_MUL_EN
              op       = OP_MUL;
              is_multi = 1'b1;
`else
              illegal  = 1'b1;
`endif
            end
          endcase
        end
      end
    endcase
  end

  assign operation = OP_W'(op);

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control slot: handshake, stall/flush, multi-cycle occupancy.
// Ports: clk, rst, alu_op, funct, in_valid/in_ready, stall, flush,
// out_valid, operation, illegal, busy, op_last. Macro ALU_CTRL_MUL_EN.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 3,
  parameter int OP_W      = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [OP_W-1:0]    operation,
  output logic               illegal,
  output logic               busy,
  output logic               op_last
);

  localparam int CW = $clog2(MC_CYCLES + 1);
  localparam logic [OP_W-1:0] NOP_C = OP_W'(OP_NOP);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;

  logic [OP_W-1:0] dec_op;
  logic            dec_multi;
  logic            dec_ill;
  logic            accept;

  alu_ctrl_decode #(
    .FUNCT_W(FUNCT_W),
    .OP_W   (OP_W)
  ) u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .operation(dec_op),
    .is_multi (dec_multi),
    .illegal  (dec_ill)
  );

  // Ready on the last EX cycle too, so ops chain without bubbles.
  assign in_ready = !stall && (cnt_q <= CW'(1));
  assign accept   = in_valid && in_ready;

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    if (flush) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
      op_d        = NOP_C;
      illegal_d   = 1'b0;
    end else if (stall) begin
      cnt_d = cnt_q;
    end else if (accept) begin
      cnt_d       = dec_multi ? CW'(MC_CYCLES) : CW'(1);
      out_valid_d = 1'b1;
      op_d        = dec_op;
      illegal_d   = dec_ill;
    end else if (cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end else if (cnt_q == CW'(1)) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
      op_d        = NOP_C;
      illegal_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      op_q        <= NOP_C;
      illegal_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign operation = op_q;
  assign illegal   = illegal_q;
  assign op_last   = out_valid_q && (cnt_q == CW'(1));
`ifdef ALU_CTRL_MUL_EN
  assign busy      = cnt_q > CW'(1);
`else
  assign busy      = 1'b0;
`endif

endmodule
